// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, stage FSM states,
// datapath widths and the constants used by the surrounding pipeline latches.
package mem_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0]     ZeroWord   = 32'h0000_0000;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b00000;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LW   = 4'd3,
        MEMOP_LBU  = 4'd4,
        MEMOP_LHU  = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
               (op == MEMOP_LBU) || (op == MEMOP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    // Byte count handed to the byte-serial controller.
    function automatic logic [2:0] op_len(input logic [3:0] op);
        logic [2:0] len;
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: len = 3'd1;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: len = 3'd2;
            MEMOP_LW, MEMOP_SW:            len = 3'd4;
            default:                       len = 3'd0;
        endcase
        return len;
    endfunction

    // Natural-alignment test on the low address bits; bytes never misalign.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lsb);
        logic bad;
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: bad = lsb[0];
            MEMOP_LW, MEMOP_SW:            bad = (lsb != 2'b00);
            default:                       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_load_fmt.sv
// Load data formatter: selects and sign/zero-extends the low bytes returned by
// the memory controller according to the load opcode. Purely combinational.
module load_fmt
    import mem_stage_pkg::*;
(
    input  logic [3:0]  memop,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Extend the significant low bytes; non-load codes pass the raw word.
    always_comb begin
        ext = raw;
        case (memop)
            MEMOP_LB:  ext = {{24{raw[7]}}, raw[7:0]};
            MEMOP_LBU: ext = {24'h000000, raw[7:0]};
            MEMOP_LH:  ext = {{16{raw[15]}}, raw[15:0]};
            MEMOP_LHU: ext = {16'h0000, raw[15:0]};
            MEMOP_LW:  ext = raw;
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline. Non-memory instructions pass straight
// through; loads/stores are issued to the byte-serial memory controller with
// a req/done handshake while the pipeline is stalled (IDLE -> BUSY -> DONE).
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned halfword/word
// accesses (no request, mem_misalign raised); otherwise mem_misalign is tied 0.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,

    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [31:0]       ex_wdata,
    input  logic [3:0]        ex_memop,
    input  logic [ADDR_W-1:0] ex_maddr,
    input  logic [31:0]       ex_sdata,

    output logic              mctl_req,
    output logic              mctl_we,
    output logic [ADDR_W-1:0] mctl_addr,
    output logic [2:0]        mctl_len,
    output logic [31:0]       mctl_wdata,
    input  logic              mctl_done,
    input  logic [31:0]       mctl_rdata,

    output logic              stallreq_mem,
    output logic [4:0]        mem_wd,
    output logic              mem_wreg,
    output logic [31:0]       mem_wdata,
    output logic              mem_misalign
);

    mem_state_t        state_reg;
    logic              mctl_req_reg;
    logic              mctl_we_reg;
    logic [ADDR_W-1:0] mctl_addr_reg;
    logic [2:0]        mctl_len_reg;
    logic [31:0]       mctl_wdata_reg;
    logic [31:0]       rdata_q;

    logic              op_is_mem;
    logic              misalign_now;
    logic              issue;
    logic [31:0]       load_data;

    assign op_is_mem = is_load(ex_memop) || is_store(ex_memop);

`ifdef MEM_ALIGN_CHECK_EN
    // A misaligned access is only judged when it would be issued from IDLE.
    assign misalign_now = (state_reg == ST_IDLE) && is_misaligned(ex_memop, ex_maddr[1:0]);
`else
    assign misalign_now = 1'b0;
`endif

    assign issue = (state_reg == ST_IDLE) && op_is_mem && !misalign_now;

    load_fmt u_load_fmt (
        .memop (ex_memop),
        .raw   (rdata_q),
        .ext   (load_data)
    );

    // Handshake FSM plus registered request fields; frozen whenever rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mctl_req_reg   <= 1'b0;
            mctl_we_reg    <= 1'b0;
            mctl_addr_reg  <= '0;
            mctl_len_reg   <= 3'd0;
            mctl_wdata_reg <= ZeroWord;
            rdata_q        <= ZeroWord;
        end else if (rdy) begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        state_reg      <= ST_BUSY;
                        mctl_req_reg   <= 1'b1;
                        mctl_we_reg    <= is_store(ex_memop);
                        mctl_addr_reg  <= ex_maddr;
                        mctl_len_reg   <= op_len(ex_memop);
                        mctl_wdata_reg <= ex_sdata;
                    end
                end
                ST_BUSY: begin
                    if (mctl_done) begin
                        state_reg    <= ST_DONE;
                        mctl_req_reg <= 1'b0;
                        rdata_q      <= mctl_rdata;
                    end
                end
                ST_DONE: begin
                    // Always leave DONE so the stalled instruction is not reissued.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    mctl_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mctl_req   = mctl_req_reg;
    assign mctl_we    = mctl_we_reg;
    assign mctl_addr  = mctl_addr_reg;
    assign mctl_len   = mctl_len_reg;
    assign mctl_wdata = mctl_wdata_reg;

    // Write-back triple and stall request, derived from state and ex_* inputs.
    always_comb begin
        mem_wd       = ex_wd;
        mem_wreg     = ex_wreg;
        mem_wdata    = ex_wdata;
        stallreq_mem = 1'b0;
        mem_misalign = misalign_now;
        if (rst) begin
            mem_wd       = NOPRegAddr;
            mem_wreg     = 1'b0;
            mem_wdata    = ZeroWord;
            stallreq_mem = 1'b0;
            mem_misalign = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (misalign_now) begin
                        mem_wreg = 1'b0;
                    end else if (op_is_mem) begin
                        mem_wreg     = 1'b0;
                        stallreq_mem = 1'b1;
                    end
                end
                ST_BUSY: begin
                    mem_wreg     = 1'b0;
                    stallreq_mem = 1'b1;
                end
                ST_DONE: begin
                    if (is_load(ex_memop)) begin
                        mem_wdata = load_data;
                        mem_wreg  = ex_wreg;
                    end else begin
                        mem_wreg = 1'b0;
                    end
                end
                default: begin
                    mem_wreg = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: pass-through, loads/stores with a simple
// controller responder, rdy freeze, reset mid-access and alignment handling.
module tb_mem_stage;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LBU  = 4'd4;
    localparam logic [3:0] OP_LHU  = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr;
    logic [31:0] ex_sdata;
    logic        mctl_req;
    logic        mctl_we;
    logic [31:0] mctl_addr;
    logic [2:0]  mctl_len;
    logic [31:0] mctl_wdata;
    logic        mctl_done;
    logic [31:0] mctl_rdata;
    logic        stallreq_mem;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_memop     (ex_memop),
        .ex_maddr     (ex_maddr),
        .ex_sdata     (ex_sdata),
        .mctl_req     (mctl_req),
        .mctl_we      (mctl_we),
        .mctl_addr    (mctl_addr),
        .mctl_len     (mctl_len),
        .mctl_wdata   (mctl_wdata),
        .mctl_done    (mctl_done),
        .mctl_rdata   (mctl_rdata),
        .stallreq_mem (stallreq_mem),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_misalign (mem_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nonmem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        ex_memop = OP_NONE;
        ex_wd    = wd;
        ex_wreg  = wreg;
        ex_wdata = wdata;
        ex_maddr = 32'h0;
        ex_sdata = 32'h0;
    endtask

    // Issue one memory op and act as a controller answering after n req-high
    // cycles (rdy-gated). Optionally drops rdy for drop_len cycles at drop_at,
    // pulsing a bogus done during the drop that must be ignored.
    task automatic do_mem(input string name, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input int n, input logic [31:0] raw,
                          input int drop_at, input int drop_len, input logic exp_we,
                          input logic [2:0] exp_len, input logic load,
                          input logic [31:0] exp_wdata);
        int   stall_cnt = 0;
        int   req_rise  = 0;
        int   wreg_cnt  = 0;
        int   bad       = 0;
        int   frozen_bad = 0;
        int   age       = 0;
        int   cyc       = 0;
        logic prev_req  = 1'b0;
        logic finished  = 1'b0;
        logic [31:0] got = 32'h0;

        ex_memop = op;
        ex_maddr = addr;
        ex_sdata = sdata;
        ex_wd    = 5'd9;
        ex_wreg  = 1'b1;
        ex_wdata = 32'h5555_AAAA;
        mctl_done = 1'b0;
        rdy = 1'b1;
        #1;
        while (!finished && cyc < 60) begin
            if (cyc > 0) tick();
            rdy = !(drop_len > 0 && cyc >= drop_at && cyc < drop_at + drop_len);
            if (mctl_req && rdy) age++;
            if (rdy) mctl_done = mctl_req && (age == n);
            else     mctl_done = (cyc == drop_at + 1);
            mctl_rdata = (rdy && mctl_done) ? raw : 32'h0BAD_F00D;
            #1;
            if (stallreq_mem) stall_cnt++;
            if (mctl_req && !prev_req) req_rise++;
            if (mctl_req && (mctl_we !== exp_we || mctl_addr !== addr ||
                             mctl_len !== exp_len || mctl_wdata !== sdata)) bad++;
            if (!rdy && (!mctl_req || !stallreq_mem)) frozen_bad++;
            if (mem_wd !== 5'd9) bad++;
            if (mem_wreg) begin
                wreg_cnt++;
                got = mem_wdata;
            end
            prev_req = mctl_req;
            if (cyc > 0 && !stallreq_mem) finished = 1'b1;
            cyc++;
        end
        mctl_done = 1'b0;
        rdy = 1'b1;
        check({name, " finished"}, 32'(finished), 32'd1);
        check({name, " stall_cycles"}, stall_cnt, n + 1 + drop_len);
        check({name, " requests"}, req_rise, 32'd1);
        check({name, " field_errs"}, bad, 32'd0);
        check({name, " freeze_errs"}, frozen_bad, 32'd0);
        check({name, " req_in_done"}, 32'(mctl_req), 32'd0);
        check({name, " wreg_cycles"}, wreg_cnt, load ? 32'd1 : 32'd0);
        if (load) check({name, " wdata"}, got, exp_wdata);
        // Following cycle: back in IDLE, so a non-memory op passes straight through.
        tick();
        set_nonmem(5'd2, 1'b1, 32'h0000_0077);
        #1;
        check({name, " next_wdata"}, mem_wdata, 32'h0000_0077);
        check({name, " next_stall"}, 32'(stallreq_mem), 32'd0);
        check({name, " next_req"}, 32'(mctl_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        mctl_done = 1'b0;
        mctl_rdata = 32'h0;
        set_nonmem(5'd5, 1'b1, 32'h0000_1234);
        tick();
        tick();

        // Reset values and forced combinational outputs.
        check("rst mem_wd", 32'(mem_wd), 32'd0);
        check("rst mem_wreg", 32'(mem_wreg), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst stall", 32'(stallreq_mem), 32'd0);
        check("rst req", 32'(mctl_req), 32'd0);
        check("rst len", 32'(mctl_len), 32'd0);
        check("rst addr", mctl_addr, 32'h0);
        check("rst misalign", 32'(mem_misalign), 32'd0);

        // Non-memory op passes through in the same cycle.
        rst = 1'b0;
        #1;
        check("add mem_wd", 32'(mem_wd), 32'd5);
        check("add mem_wdata", mem_wdata, 32'h0000_1234);
        check("add mem_wreg", 32'(mem_wreg), 32'd1);
        check("add stall", 32'(stallreq_mem), 32'd0);
        tick();
        tick();
        check("add req", 32'(mctl_req), 32'd0);

        // Stray done in IDLE must be ignored.
        mctl_done = 1'b1;
        mctl_rdata = 32'hFFFF_FFFF;
        tick();
        mctl_done = 1'b0;
        #1;
        check("idle_done stall", 32'(stallreq_mem), 32'd0);
        check("idle_done req", 32'(mctl_req), 32'd0);
        check("idle_done wdata", mem_wdata, 32'h0000_1234);

        do_mem("lb",  OP_LB,  32'h0000_1001, 32'h0,         3, 32'h0000_0080, 0, 0, 1'b0, 3'd1, 1'b1, 32'hFFFF_FF80);
        do_mem("sw",  OP_SW,  32'h0000_2000, 32'hDEAD_BEEF, 2, 32'h0,         0, 0, 1'b1, 3'd4, 1'b0, 32'h0);
        do_mem("lhu", OP_LHU, 32'h0000_0040, 32'h0,         3, 32'h1234_FFFF, 2, 5, 1'b0, 3'd2, 1'b1, 32'h0000_FFFF);
        do_mem("lh",  OP_LH,  32'h0000_0012, 32'h0,         1, 32'h0000_8001, 0, 0, 1'b0, 3'd2, 1'b1, 32'hFFFF_8001);
        do_mem("lw",  OP_LW,  32'h0000_0104, 32'h0,         2, 32'hCAFE_F00D, 0, 0, 1'b0, 3'd4, 1'b1, 32'hCAFE_F00D);
        do_mem("lbu", OP_LBU, 32'h0000_0007, 32'h0,         1, 32'hABCD_EF90, 0, 0, 1'b0, 3'd1, 1'b1, 32'h0000_0090);
        do_mem("sb",  OP_SB,  32'h0000_0003, 32'h1122_3344, 1, 32'h0,         0, 0, 1'b1, 3'd1, 1'b0, 32'h0);
        do_mem("sh",  OP_SH,  32'h0000_0006, 32'h5566_7788, 2, 32'h0,         0, 0, 1'b1, 3'd2, 1'b0, 32'h0);

        // Reset while BUSY aborts the access.
        ex_memop = OP_LW;
        ex_maddr = 32'h0000_0200;
        ex_wd    = 5'd7;
        ex_wreg  = 1'b1;
        tick();
        check("rstbusy req_before", 32'(mctl_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rstbusy stall_forced", 32'(stallreq_mem), 32'd0);
        tick();
        check("rstbusy req", 32'(mctl_req), 32'd0);
        check("rstbusy addr", mctl_addr, 32'h0);
        check("rstbusy len", 32'(mctl_len), 32'd0);
        check("rstbusy mem_wd", 32'(mem_wd), 32'd0);
        check("rstbusy mem_wreg", 32'(mem_wreg), 32'd0);
        rst = 1'b0;
        set_nonmem(5'd3, 1'b1, 32'h0000_0ABC);
        #1;
        check("rstbusy idle_wdata", mem_wdata, 32'h0000_0ABC);
        check("rstbusy idle_stall", 32'(stallreq_mem), 32'd0);
        tick();

        // Misaligned word access.
        ex_memop = OP_LW;
        ex_maddr = 32'h0000_3002;
        ex_wd    = 5'd9;
        ex_wreg  = 1'b1;
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        check("mis flag", 32'(mem_misalign), 32'd1);
        check("mis stall", 32'(stallreq_mem), 32'd0);
        check("mis wreg", 32'(mem_wreg), 32'd0);
        tick();
        check("mis req", 32'(mctl_req), 32'd0);
        set_nonmem(5'd1, 1'b0, 32'h0);
        tick();
`else
        check("mis flag", 32'(mem_misalign), 32'd0);
        check("mis stall", 32'(stallreq_mem), 32'd1);
        do_mem("lw_unal", OP_LW, 32'h0000_3002, 32'h0, 1, 32'h0102_0304, 0, 0, 1'b0, 3'd4, 1'b1, 32'h0102_0304);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline. Sits between the EX/MEM latch and the MEM/WB latch. Non-memory instructions pass through in the same cycle. Loads and stores go through a request/done handshake with the byte-serial memory controller, with `stallreq_mem` held while the access is in flight. It produces the write-back triple (`mem_wd`, `mem_wreg`, `mem_wdata`) consumed by the MEM/WB latch.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready. When low, the block is frozen.
- `ex_wd` in 5: destination register.
- `ex_wreg` in 1: register write enable.
- `ex_wdata` in 32: ALU result, passed through for non-loads.
- `ex_memop` in 4: memory operation code (see Structure).
- `ex_maddr` in ADDR_W: effective address.
- `ex_sdata` in 32: store data (rs2).
- `mctl_req` out 1: access request, registered.
- `mctl_we` out 1: 1 = store.
- `mctl_addr` out ADDR_W: access address.
- `mctl_len` out 3: byte count, 1, 2 or 4.
- `mctl_wdata` out 32: store data, low bytes significant.
- `mctl_done` in 1: one-cycle completion pulse.
- `mctl_rdata` in 32: load data, valid with `mctl_done`.
- `stallreq_mem` out 1: stall request to the pipeline controller.
- `mem_wd` out 5: write-back destination register.
- `mem_wreg` out 1: write-back enable.
- `mem_wdata` out 32: write-back data.
- `mem_misalign` out 1: misaligned-access flag (only when `MEM_ALIGN_CHECK_EN` is defined; otherwise tied 0).

## Operation
- State machine states: IDLE, BUSY, DONE. Register `rdata_q` (32 bits).
- **IDLE**
  - `ex_memop` = NONE: outputs come combinationally from the `ex_*` inputs; `stallreq_mem` = 0.
  - Otherwise: `stallreq_mem` = 1 and `mem_wreg` = 0. At the next edge the state goes to BUSY and `mctl_req`, `mctl_we`, `mctl_addr`, `mctl_len`, `mctl_wdata` are registered.
- **BUSY**
  - `mctl_req` is held at 1 with all request fields stable; `stallreq_mem` = 1; `mem_wreg` = 0.
  - On `mctl_done`: capture `mctl_rdata` into `rdata_q`, drop `mctl_req`, go to DONE.
- **DONE**
  - `stallreq_mem` = 0. The instruction is still present on `ex_*` because the pipeline was stalled.
  - Loads: `mem_wdata` = `rdata_q` formatted by op, `mem_wreg` = `ex_wreg`.
  - Stores: `mem_wreg` = 0.
  - Next edge returns to IDLE unconditionally; this stops the same instruction being issued twice.
- Load formatting:
  - LB: sign-extend bits 7:0.
  - LBU: zero-extend bits 7:0.
  - LH: sign-extend bits 15:0.
  - LHU: zero-extend bits 15:0.
  - LW: all 32 bits.
- `mctl_len`: 1 for byte ops, 2 for halfword ops, 4 for word ops.
- `mctl_wdata` = `ex_sdata` unmasked; the controller uses only `mctl_len` bytes.
- `mem_wd` = `ex_wd` in every state.

## Timing
- Reset values: state IDLE, `mctl_req` 0, `mctl_we` 0, `mctl_addr` 0, `mctl_len` 0, `mctl_wdata` 0, `rdata_q` 0, `mem_misalign` 0. While `rst` is high, the combinational outputs are forced to `mem_wreg` 0, `mem_wd` 0, `mem_wdata` 0, `stallreq_mem` 0.
- Latency: non-memory ops add 0 cycles. A memory op with controller latency N (N ≥ 1 cycles from `mctl_req` high to `mctl_done`) stalls for N+1 cycles, and the result appears in the DONE cycle.
- `rst` mid-access: the state machine aborts and `mctl_req` falls the next cycle. The controller must tolerate request withdrawal.
- `rdy` = 0: all registers hold and `mctl_done` is ignored. The controller is gated by the same `rdy`, so no done pulse is lost.
- A `mctl_done` that arrives in IDLE or DONE is ignored.
- `stallreq_mem` is never high in the cycle the state machine leaves DONE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, an LH/LHU/SH with `ex_maddr[0]` = 1, or an LW/SW with `ex_maddr[1:0]` ≠ 0, issues no request.
  - `mem_misalign` = 1 and `mem_wreg` = 0 in that cycle; `stallreq_mem` = 0.
- `MEM_ALIGN_CHECK_EN` not defined: any alignment is accepted (the controller is byte-serial) and `mem_misalign` is tied 0.

## Structure
- Shared package/defines header:
  - `memop` encodings: NONE = 0, LB, LH, LW, LBU, LHU, SB, SH, SW.
  - State encodings.
  - The `RegBus`/`RegAddrBus` widths and `ZeroWord`/`NOPRegAddr` constants already used by the latches.
- One sub-module, `load_fmt`: a combinational formatter (`memop`, raw 32 bits → extended 32 bits).

## Test plan
- Non-memory op (ADD, `ex_wd` = 5, `ex_wdata` = 0x1234) → same cycle: `mem_wd` = 5, `mem_wdata` = 0x1234, `stallreq_mem` = 0, `mctl_req` never high.
- LB at 0x1001 with the controller returning 0x00000080 after 3 cycles → `stallreq_mem` high for 4 cycles; then `mem_wdata` = 0xFFFFFF80 and `mem_wreg` = 1 for exactly one cycle.
- SW of 0xDEADBEEF at 0x2000 → `mctl_we` = 1, `mctl_len` = 4, `mctl_addr` = 0x2000, stable until done; `mem_wreg` = 0 throughout; exactly one request issued.
- LHU with `rdy` dropped for 5 cycles mid-BUSY → state and request fields unchanged during the drop; result 0x0000FFFF for raw data 0x1234FFFF.
- `rst` asserted in BUSY → next cycle `mctl_req` = 0, state IDLE, all outputs at reset values.
- With `MEM_ALIGN_CHECK_EN` defined, LW at 0x3002 → `mem_misalign` = 1, no `mctl_req`, `mem_wreg` = 0, `stallreq_mem` = 0.
